// File: rtl/udp_pkt_framer_if.sv
// rtl/udp_pkt_framer_if.sv - byte-wide AXI-Stream style link used on both sides of the framer
interface udp_pkt_framer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/udp_pkt_framer.sv
// rtl/udp_pkt_framer.sv - buffers one UDP payload in RAM, replays it with UDP/IP length and checksum fields
// Optional payload checksum generation: define UDP_PKT_FRAMER_CSUM_EN.
module udp_pkt_framer #(
    parameter int MAX_PAYLOAD = 1472,
    parameter int ADDR_W      = 11
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_aresetn,
    udp_pkt_framer_if.slave        s_axis,
    udp_pkt_framer_if.master       m_axis,
    input  logic [31:0]            IP_SrcAddr,
    input  logic [31:0]            IP_DestAddr,
    input  logic [15:0]            UDP_SrcPort,
    input  logic [15:0]            UDP_DestPort,
    output logic [15:0]            UDP_TotLen,
    output logic [15:0]            IP_TotLen,
    output logic [15:0]            UDP_CheckSum,
    output logic                   pkt_busy
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [1:0] {FILL, FINAL, SEND} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ram [0:(1<<ADDR_W)-1];
    logic [15:0] wr_cnt_q, rd_addr_q;
    logic [15:0] udp_len_q, ip_len_q;
    logic [7:0]  rd_data_q, m_tdata_q;
    logic        rd_vld_q, rd_first_q, rd_last_q;
    logic        m_tvalid_q, m_tuser_q, m_tlast_q;

    logic [15:0] wr_cnt_inc, udp_len_w;
    logic        s_fire, m_fire, out_ready, rd_adv, rd_more, rd_en, pkt_done;
    logic        unused_tuser;

    assign unused_tuser = s_axis.tuser;

    assign s_axis.tready = (state_q == FILL);
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tuser  = m_tuser_q;
    assign m_axis.tlast  = m_tlast_q;
    assign UDP_TotLen    = udp_len_q;
    assign IP_TotLen     = ip_len_q;
    assign pkt_busy      = (state_q != FILL);

    always_comb begin
        state_d    = state_q;
        wr_cnt_inc = wr_cnt_q + 16'd1;
        udp_len_w  = wr_cnt_q + 16'd8;
        s_fire     = (state_q == FILL) && s_axis.tvalid;
        m_fire     = m_tvalid_q && m_axis.tready;
        out_ready  = !m_tvalid_q || m_axis.tready;
        // The read stage refills whenever it is empty or its byte moves to the output register.
        rd_adv     = (state_q == FINAL) || ((state_q == SEND) && (!rd_vld_q || out_ready));
        rd_more    = (rd_addr_q < wr_cnt_q);
        rd_en      = rd_adv && rd_more;
        pkt_done   = (state_q == SEND) && m_fire && m_tlast_q;
        case (state_q)
            FILL:    if (s_fire && (s_axis.tlast || wr_cnt_inc == MAX_LEN)) state_d = FINAL;
            FINAL:   state_d = SEND;
            SEND:    if (pkt_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) state_q <= FILL;
        else                 state_q <= state_d;
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_fire) ram[wr_cnt_q[ADDR_W-1:0]] <= s_axis.tdata;
        if (rd_en)  rd_data_q <= ram[rd_addr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            wr_cnt_q   <= '0;
            rd_addr_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tuser_q  <= 1'b0;
            m_tlast_q  <= 1'b0;
            udp_len_q  <= '0;
            ip_len_q   <= '0;
        end else begin
            if (s_fire) wr_cnt_q <= wr_cnt_inc;
            if (state_q == FINAL) begin
                udp_len_q <= udp_len_w;
                ip_len_q  <= wr_cnt_q + 16'd28;
            end
            if (rd_adv) begin
                rd_vld_q   <= rd_more;
                rd_first_q <= (rd_addr_q == 16'd0);
                rd_last_q  <= (rd_addr_q == wr_cnt_q - 16'd1);
                if (rd_more) rd_addr_q <= rd_addr_q + 16'd1;
            end
            if ((state_q == SEND) && out_ready) begin
                m_tvalid_q <= rd_vld_q;
                if (rd_vld_q) begin
                    m_tdata_q <= rd_data_q;
                    m_tuser_q <= rd_first_q;
                    m_tlast_q <= rd_last_q;
                end
            end
            if (pkt_done) begin
                wr_cnt_q   <= '0;
                rd_addr_q  <= '0;
                rd_vld_q   <= 1'b0;
                m_tvalid_q <= 1'b0;
                m_tuser_q  <= 1'b0;
                m_tlast_q  <= 1'b0;
            end
        end
    end

`ifdef UDP_PKT_FRAMER_CSUM_EN
    logic [31:0] acc_q, byte_word, sum_w;
    logic [16:0] fold1;
    logic [15:0] fold2, csum_w, csum_q;

    always_comb begin
        // Even byte offsets are the high half of a big-endian word; odd ones the low half.
        byte_word = wr_cnt_q[0] ? {24'h0, s_axis.tdata} : {16'h0, s_axis.tdata, 8'h00};
        sum_w     = acc_q
                  + {16'h0, IP_SrcAddr[31:16]}  + {16'h0, IP_SrcAddr[15:0]}
                  + {16'h0, IP_DestAddr[31:16]} + {16'h0, IP_DestAddr[15:0]}
                  + 32'h0000_0011 + {16'h0, udp_len_w}
                  + {16'h0, UDP_SrcPort} + {16'h0, UDP_DestPort} + {16'h0, udp_len_w};
        fold1     = {1'b0, sum_w[15:0]} + {1'b0, sum_w[31:16]};
        fold2     = fold1[15:0] + {15'h0, fold1[16]};
        csum_w    = ~fold2;
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            acc_q  <= '0;
            csum_q <= '0;
        end else if (state_q == FINAL) begin
            acc_q  <= '0;
            csum_q <= (csum_w == 16'h0000) ? 16'hFFFF : csum_w;
        end else if (s_fire) begin
            acc_q  <= acc_q + byte_word;
        end
    end

    assign UDP_CheckSum = csum_q;
`else
    logic unused_hdr;
    assign unused_hdr   = ^{IP_SrcAddr, IP_DestAddr, UDP_SrcPort, UDP_DestPort};
    assign UDP_CheckSum = 16'h0000;
`endif
endmodule

// File: tb/tb_udp_pkt_framer.sv
// tb/tb_udp_pkt_framer.sv - directed self-checking bench for udp_pkt_framer
module tb_udp_pkt_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [31:0] ip_src, ip_dst;
    logic [15:0] sport, dport, udp_len, ip_len, csum;
    logic        busy;

    udp_pkt_framer_if s_if ();
    udp_pkt_framer_if m_if ();

    udp_pkt_framer #(.MAX_PAYLOAD(1472), .ADDR_W(11)) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(resetn),
        .s_axis(s_if.slave), .m_axis(m_if.master),
        .IP_SrcAddr(ip_src), .IP_DestAddr(ip_dst),
        .UDP_SrcPort(sport), .UDP_DestPort(dport),
        .UDP_TotLen(udp_len), .IP_TotLen(ip_len), .UDP_CheckSum(csum),
        .pkt_busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  got_d[$];
    bit          got_u[$], got_l[$];
    int          pkt_len[$];
    logic [15:0] pkt_udp[$], pkt_ip[$];
    logic [7:0]  stim[$];
    int          beats_in_pkt = 0;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_beat;

    // Output monitor: samples between the driving negedge and the next active edge.
    always begin
        @(negedge clk);
        #2;
        if (resetn) begin
            if (prev_stall) begin
                chk("hold_valid", m_if.tvalid, 1);
                chk("hold_beat", {m_if.tdata, m_if.tuser, m_if.tlast}, prev_beat);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_beat  = {m_if.tdata, m_if.tuser, m_if.tlast};
            if (m_if.tvalid && m_if.tready) begin
                got_d.push_back(m_if.tdata);
                got_u.push_back(m_if.tuser);
                got_l.push_back(m_if.tlast);
                beats_in_pkt++;
                if (m_if.tlast) begin
                    pkt_len.push_back(beats_in_pkt);
                    pkt_udp.push_back(udp_len);
                    pkt_ip.push_back(ip_len);
                    beats_in_pkt = 0;
                end
            end
        end else begin
            prev_stall   = 1'b0;
            beats_in_pkt = 0;
        end
    end

    task automatic clear_q();
        got_d.delete(); got_u.delete(); got_l.delete();
        pkt_len.delete(); pkt_udp.delete(); pkt_ip.delete();
    endtask

    task automatic send_stream(input bit last_end);
        for (int i = 0; i < stim.size(); i++) begin
            int t = 0;
            s_if.tvalid = 1'b1;
            s_if.tdata  = stim[i];
            s_if.tlast  = last_end && (i == stim.size() - 1);
            while (!s_if.tready && t < 4000) begin
                @(negedge clk);
                t++;
            end
            if (!s_if.tready) chk("in_timeout", 0, 1);
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_pkts(input int n, input bit stall);
        int t = 0;
        while (pkt_len.size() < n && t < 5000) begin
            if (stall) m_if.tready = ~m_if.tready;
            if (busy) chk("in_rdy_busy", s_if.tready, 0);
            @(negedge clk);
            t++;
        end
        chk("pkts_done", pkt_len.size(), n);
        m_if.tready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int errs, nu, nl;
        resetn = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = 8'h00; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        m_if.tready = 1'b1;
        ip_src = 32'hC0A8_010A; ip_dst = 32'hC0A8_0114; sport = 16'd1234; dport = 16'd5678;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_in_rdy", s_if.tready, 1);
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tlast_tuser", {m_if.tlast, m_if.tuser}, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_lens", {udp_len, ip_len}, 0);
        chk("rst_csum", csum, 0);
        chk("rst_busy", busy, 0);

        // Four bytes, latency and header fields
        clear_q();
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_stream(1);
        chk("fin_in_rdy", s_if.tready, 0);
        chk("fin_busy", busy, 1);
        chk("close1_tvalid", m_if.tvalid, 0);
        @(negedge clk);
        chk("close1p_tvalid", m_if.tvalid, 0);
        chk("p4_udp_len", udp_len, 12);
        chk("p4_ip_len", ip_len, 32);
        @(negedge clk);
        chk("close2_tvalid", m_if.tvalid, 1);
        chk("close2_first", {m_if.tdata, m_if.tuser}, {8'h01, 1'b1});
        wait_pkts(1, 0);
        chk("p4_beats", got_d.size(), 4);
        chk("p4_data", {got_d[0], got_d[1], got_d[2], got_d[3]}, 32'h01020304);
        chk("p4_tuser", {got_u[0], got_u[1], got_u[2], got_u[3]}, 4'b1000);
        chk("p4_tlast", {got_l[0], got_l[1], got_l[2], got_l[3]}, 4'b0001);
        chk("p4_after_rdy", s_if.tready, 1);
        chk("p4_after_busy", busy, 0);
        chk("p4_hold_len", udp_len, 12);

        // 1500 bytes: forced split at 1472, then tlast closes a 28-byte packet
        clear_q();
        stim.delete();
        for (int i = 0; i < 1500; i++) stim.push_back(8'(i));
        send_stream(1);
        wait_pkts(2, 0);
        chk("big_beats", got_d.size(), 1500);
        errs = 0; nu = 0; nl = 0;
        for (int i = 0; i < got_d.size(); i++) begin
            if (got_d[i] !== 8'(i)) errs++;
            nu += int'(got_u[i]);
            nl += int'(got_l[i]);
        end
        chk("big_order_errs", errs, 0);
        chk("big_tuser_cnt", nu, 2);
        chk("big_tlast_cnt", nl, 2);
        chk("big_split_flags", {got_l[1471], got_u[1472], got_l[1499]}, 3'b111);
        chk("big_p0_len", pkt_len[0], 1472);
        chk("big_p0_hdr", {pkt_udp[0], pkt_ip[0]}, {16'd1480, 16'd1500});
        chk("big_p1_len", pkt_len[1], 28);
        chk("big_p1_hdr", {pkt_udp[1], pkt_ip[1]}, {16'd36, 16'd56});

        // Eight bytes with alternating downstream ready
        clear_q();
        stim = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
        send_stream(1);
        m_if.tready = 1'b0;
        wait_pkts(1, 1);
        chk("stall_beats", got_d.size(), 8);
        errs = 0;
        for (int i = 0; i < got_d.size(); i++)
            if (got_d[i] !== stim[i]) errs++;
        chk("stall_data_errs", errs, 0);
        chk("stall_hdr", {udp_len, ip_len}, {16'd16, 16'd36});

        // Single byte
        clear_q();
        stim = '{8'hAA};
        send_stream(1);
        wait_pkts(1, 0);
        chk("one_beats", got_d.size(), 1);
        chk("one_beat", {got_d[0], got_u[0], got_l[0]}, {8'hAA, 2'b11});
        chk("one_hdr", {udp_len, ip_len}, {16'd9, 16'd29});

        // Reset in the middle of a replay
        clear_q();
        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(1);
        begin
            int t = 0;
            while (got_d.size() < 2 && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        chk("mid_two_sent", got_d.size(), 2);
        resetn = 1'b0;
        m_if.tready = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", m_if.tvalid, 0);
        chk("mid_rst_lens", {udp_len, ip_len}, 0);
        chk("mid_rst_busy", busy, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_rel_rdy", s_if.tready, 1);
        m_if.tready = 1'b1;
        clear_q();
        stim = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        send_stream(1);
        wait_pkts(1, 0);
        chk("post_beats", got_d.size(), 5);
        chk("post_data", {got_d[0], got_d[1], got_d[2], got_d[3], got_d[4]}, 40'h0506070809);
        chk("post_flags", {got_u[0], got_l[4], got_u[4], got_l[0]}, 4'b1100);
        chk("post_hdr", {udp_len, ip_len}, {16'd13, 16'd33});

        // Checksum packet
        clear_q();
        stim = '{8'h41, 8'h42, 8'h43};
        send_stream(1);
        wait_pkts(1, 0);
        chk("cs_udp_len", udp_len, 11);
`ifdef UDP_PKT_FRAMER_CSUM_EN
        chk("cs_value", csum, 16'hDD26);
`else
        chk("cs_value", csum, 16'h0000);
`endif
        chk("cs_data", {got_d[0], got_d[1], got_d[2]}, 24'h414243);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
